pipe_stage: RTL
===============

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64: width of the datapath payload (e.g. alu_data + rs2_data).
REQ-002 The block SHALL have parameter CTRL_W, default 8: width of the control payload (rd_wren, is_load, mem_wren, wb_sel, mem_op).
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction value presented when no valid entry is held.
REQ-004 The block SHALL have port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port flush_i, input, 1: discard all held entries (branch/exception kill).
REQ-007 The block SHALL have ports valid_i (input, 1) and ready_o (output, 1): upstream handshake.
REQ-008 The block SHALL have ports pc_i and instr_i (input, 32), ctrl_i (input, CTRL_W) and data_i (input, DATA_W): upstream payload.
REQ-009 The block SHALL have ports valid_o (output, 1) and ready_i (input, 1): downstream handshake.
REQ-010 The block SHALL have ports pc_o and instr_o (output, 32), ctrl_o (output, CTRL_W) and data_o (output, DATA_W): downstream payload.
REQ-011 The block SHALL have port count_o, output, 2: number of held entries (0..2).

Function
REQ-012 A transfer SHALL occur on a side when valid and ready are both 1 at a rising edge.
REQ-013 Storage SHALL be a main register plus one skid register.
REQ-014 The state machine SHALL have states EMPTY (0 entries), BUSY (main only) and FULL (main+skid).
REQ-015 ready_o SHALL be a registered output equal to (state != FULL), with no combinational path from ready_i.
REQ-016 Outputs SHALL always be driven from the main register; latency input->output is 1 cycle.
REQ-017 EMPTY + in -> BUSY.
REQ-018 BUSY: in and out -> BUSY with main reloaded; in only -> FULL with skid loaded; out only -> EMPTY; neither -> BUSY.
REQ-019 FULL: out -> BUSY with skid moved to main; no in is accepted since ready_o=0.
REQ-020 While valid_o=1 and ready_i=0, all output payload SHALL hold stable.
REQ-021 Order SHALL be preserved: the skid entry is never output before main.
REQ-022 When valid_o=0, instr_o SHALL equal NOP_INSTR and ctrl_o SHALL be 0, regardless of stored contents; pc_o and data_o are don't-care but SHALL hold their last values.
REQ-023 flush_i=1 at an edge SHALL force state EMPTY, valid_o=0 and count_o=0 next cycle, and SHALL ignore a simultaneous upstream transfer.
REQ-024 flush_i SHALL have priority over every handshake; ready_o SHALL be 1 the cycle after a flush.
REQ-025 count_o SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-026 valid_o SHALL equal (count_o != 0).

Reset
REQ-027 rst_i=1 SHALL asynchronously force: state EMPTY, valid_o=0, ready_o=1, count_o=0, instr_o=NOP_INSTR, ctrl_o=0, pc_o=0, data_o=0, skid register=0.
REQ-028 Reset asserted mid-transfer SHALL discard both entries; the first accept after release SHALL occur on the first edge with rst_i=0.

Structure
REQ-029 Package pipe_pkg SHALL hold the state enum (EMPTY, BUSY, FULL) and the constant NOP_INSTR default.
REQ-030 The payload SHALL be packed into one struct/vector internally so main and skid registers are identical.
REQ-031 No sub-module is required; a single always_ff with asynchronous reset plus a combinational next-state block is the intended structure.

Verification
REQ-032 Reset: assert rst_i between edges -> outputs take reset values immediately; instr_o=32'h13, ready_o=1.
REQ-033 Streaming: valid_i=1 and ready_i=1 for 8 cycles, pc 0x0..0x1C -> pc_o follows one cycle later, count_o=1 steady, no drops.
REQ-034 Backpressure: ready_i=0 and send pc 0x100, then 0x104 -> count_o=2, ready_o=0, pc_o=0x100 held; release ready_i -> 0x100 then 0x104 out in order.
REQ-035 Flush in FULL with simultaneous valid_i (pc 0x200) -> next cycle valid_o=0, instr_o=0x13, ctrl_o=0, count_o=0; 0x200 never appears.
REQ-036 Random valid_i/ready_i/flush_i over 10k cycles against a scoreboard queue model -> no loss, duplication or reorder, and outputs stable under stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and NOP default for the skid-buffered pipe stage
package pipe_pkg;

  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - two-entry pipeline register (main + skid) with registered ready and flush
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          CTRL_W    = 8,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } payload_t;

  pipe_state_t state_q, state_d;
  payload_t    main_q, skid_q, in_pl;
  logic        in_fire, out_fire;
  logic        load_main, load_skid, move_skid;

  assign in_pl    = '{pc: pc_i, instr: instr_i, ctrl: ctrl_i, data: data_i};
  assign valid_o  = (state_q != EMPTY);
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d   = BUSY;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ready_o is a flop fed from the next state, so ready_i never reaches it combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ready_o <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d != FULL);
      if (load_main) main_q <= in_pl;
      else if (move_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_pl;
    end
  end

  assign count_o = state_q;
  assign pc_o    = main_q.pc;
  assign data_o  = main_q.data;
  assign instr_o = valid_o ? main_q.instr : NOP_INSTR;
  assign ctrl_o  = valid_o ? main_q.ctrl : '0;

endmodule
